cache_requester: RTL and testbench



---
 rtl/cache_pkg.sv | 10 +
 rtl/sat_counter.sv | 13 +
 rtl/cache_requester.sv | 85 ++++++++
 tb/tb_cache_requester.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the data-cache requester.
package cache_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} req_state_t;
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;
   localparam int WORD_ALIGN_BITS = 2;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] count_o
);
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) count_o <= '0;
      else if (inc_i && !(&count_o)) count_o <= count_o + CNT_WIDTH'(1);
endmodule

// File: rtl/cache_requester.sv
// cache_requester: single-outstanding load/store initiator for the data cache processor port.
module cache_requester
   import cache_pkg::*;
#(
   parameter int TIMEOUT   = 256,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [31:0]          req_addr_i,
   input  logic [31:0]          req_wdata_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [31:0]          resp_rdata_o,
   output logic                 resp_err_o,
   output logic                 cache_en_o,
   output logic                 cache_we_o,
   output logic [31:0]          cache_addr_o,
   output logic [31:0]          cache_wdata_o,
   input  logic                 cache_hit_i,
   input  logic [31:0]          cache_rdata_i,
   output logic [CNT_WIDTH-1:0] req_cnt_o,
   output logic [CNT_WIDTH-1:0] miss_cnt_o
);
   localparam int TW = $clog2(TIMEOUT);
   req_state_t    state_q;
   mem_req_t      req_q;
   logic [TW-1:0] tmo_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic          busy, accept, misaligned, timed_out, miss_inc;
   assign busy       = state_q == BUSY;
   assign req_ready_o = state_q == IDLE;
   assign accept     = req_valid_i & req_ready_o;
   assign misaligned = req_addr_i[WORD_ALIGN_BITS-1:0] != '0;
   assign timed_out  = tmo_q == TW'(TIMEOUT - 1);
   assign miss_inc   = busy & (tmo_q == '0) & ~cache_hit_i;
   // Cache lines come only from state and latched request, never straight from req_*.
   assign cache_en_o    = busy;
   assign cache_we_o    = busy & req_q.we;
   assign cache_addr_o  = busy ? req_q.addr : '0;
   assign cache_wdata_o = busy ? req_q.wdata : '0;
   assign resp_valid_o  = state_q == RESP;
   assign resp_rdata_o  = rdata_q;
   assign resp_err_o    = err_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= IDLE;
         req_q   <= '0;
         tmo_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               req_q   <= '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};
               tmo_q   <= '0;
               rdata_q <= '0;
               err_q   <= misaligned;
               state_q <= misaligned ? RESP : BUSY;
            end
            // A hit wins over a simultaneous timeout.
            BUSY: if (cache_hit_i) begin
               rdata_q <= req_q.we ? '0 : cache_rdata_i;
               err_q   <= 1'b0;
               state_q <= RESP;
            end else if (timed_out) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
               state_q <= RESP;
            end else tmo_q <= tmo_q + TW'(1);
            RESP: if (resp_ready_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_req_cnt (
      .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(accept), .count_o(req_cnt_o)
   );
   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
      .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(miss_inc), .count_o(miss_cnt_o)
   );
endmodule

// File: tb/tb_cache_requester.sv
// tb_cache_requester: directed checks of the cache requester and its saturating counter.
module tb_cache_requester;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic        req_valid = 0, req_we = 0, resp_ready = 0, cache_hit = 0;
   logic [31:0] req_addr = 0, req_wdata = 0, cache_rdata = 0;
   logic        req_ready, resp_valid, resp_err, cache_en, cache_we;
   logic [31:0] resp_rdata, cache_addr, cache_wdata, req_cnt, miss_cnt;
   logic        t8_req_ready, t8_resp_valid, t8_resp_err, t8_cache_en, t8_cache_we;
   logic [31:0] t8_resp_rdata, t8_cache_addr, t8_cache_wdata, t8_req_cnt, t8_miss_cnt;
   logic        sat_inc = 0;
   logic [1:0]  sat_cnt;
   int checks = 0, errors = 0;
   cache_requester dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
      .resp_err_o(resp_err), .cache_en_o(cache_en), .cache_we_o(cache_we),
      .cache_addr_o(cache_addr), .cache_wdata_o(cache_wdata), .cache_hit_i(cache_hit),
      .cache_rdata_i(cache_rdata), .req_cnt_o(req_cnt), .miss_cnt_o(miss_cnt)
   );
   cache_requester #(.TIMEOUT(8)) dut_t8 (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(t8_req_ready),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(t8_resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(t8_resp_rdata),
      .resp_err_o(t8_resp_err), .cache_en_o(t8_cache_en), .cache_we_o(t8_cache_we),
      .cache_addr_o(t8_cache_addr), .cache_wdata_o(t8_cache_wdata), .cache_hit_i(cache_hit),
      .cache_rdata_i(cache_rdata), .req_cnt_o(t8_req_cnt), .miss_cnt_o(t8_miss_cnt)
   );
   sat_counter #(.CNT_WIDTH(2)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .inc_i(sat_inc), .count_o(sat_cnt)
   );
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask
   task automatic reset_dut();
      req_valid = 0; resp_ready = 1; cache_hit = 0; sat_inc = 0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask
   task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1;
      @(negedge clk);
      req_valid = 0;
   endtask
   initial begin
      int n;
      reset_dut();
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_cache_en", cache_en, 0);
      check("rst_cache_addr", cache_addr, 0);
      check("rst_req_cnt", req_cnt, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      sat_inc = 1;
      @(negedge clk);
      check("sat_one", {30'd0, sat_cnt}, 1);
      repeat (4) @(negedge clk);
      check("sat_hold", {30'd0, sat_cnt}, 3);
      sat_inc = 0;
      // load hit in first BUSY cycle
      reset_dut();
      cache_hit = 1; cache_rdata = 32'hDEADBEEF;
      send(0, 32'h40, 0);
      check("ld_en", cache_en, 1);
      check("ld_addr", cache_addr, 32'h40);
      check("ld_we", cache_we, 0);
      check("ld_req_ready", req_ready, 0);
      @(negedge clk);
      check("ld_resp_valid", resp_valid, 1);
      check("ld_rdata", resp_rdata, 32'hDEADBEEF);
      check("ld_err", resp_err, 0);
      check("ld_en_off", cache_en, 0);
      check("ld_req_cnt", req_cnt, 1);
      check("ld_miss_cnt", miss_cnt, 0);
      @(negedge clk);
      check("ld_idle_valid", resp_valid, 0);
      check("ld_idle_ready", req_ready, 1);
      // store, hit on 10th BUSY cycle
      reset_dut();
      cache_hit = 0; cache_rdata = 32'hAAAA5555;
      send(1, 32'h100, 32'h12345678);
      n = 0;
      for (int i = 0; i < 40 && !resp_valid; i++) begin
         if (cache_en) begin
            n++;
            check("st_we", cache_we, 1);
            check("st_addr", cache_addr, 32'h100);
            check("st_wdata", cache_wdata, 32'h12345678);
         end
         cache_hit = (n == 10);
         @(negedge clk);
      end
      cache_hit = 0;
      check("st_en_cycles", n, 10);
      check("st_resp_valid", resp_valid, 1);
      check("st_en_off", cache_en, 0);
      check("st_rdata", resp_rdata, 0);
      check("st_err", resp_err, 0);
      check("st_miss_cnt", miss_cnt, 1);
      check("st_req_cnt", req_cnt, 1);
      // misaligned load
      reset_dut();
      cache_hit = 1;
      send(0, 32'h42, 0);
      check("mis_en", cache_en, 0);
      check("mis_resp_valid", resp_valid, 1);
      check("mis_err", resp_err, 1);
      check("mis_rdata", resp_rdata, 0);
      check("mis_req_cnt", req_cnt, 1);
      check("mis_miss_cnt", miss_cnt, 0);
      @(negedge clk);
      check("mis_en_after", cache_en, 0);
      cache_hit = 0;
      // TIMEOUT=8 with no hit
      reset_dut();
      cache_rdata = 32'h55AA55AA;
      send(0, 32'h200, 0);
      n = 0;
      for (int i = 0; i < 40 && !t8_resp_valid; i++) begin
         if (t8_cache_en) n++;
         @(negedge clk);
      end
      check("to_busy_cycles", n, 8);
      check("to_resp_valid", t8_resp_valid, 1);
      check("to_err", t8_resp_err, 1);
      check("to_rdata", t8_resp_rdata, 0);
      // TIMEOUT=8 with hit on the last allowed cycle
      reset_dut();
      send(0, 32'h200, 0);
      n = 0;
      for (int i = 0; i < 40 && !t8_resp_valid; i++) begin
         if (t8_cache_en) n++;
         cache_hit = (n == 8);
         @(negedge clk);
      end
      cache_hit = 0;
      check("tohit_busy_cycles", n, 8);
      check("tohit_resp_valid", t8_resp_valid, 1);
      check("tohit_err", t8_resp_err, 0);
      check("tohit_rdata", t8_resp_rdata, 32'h55AA55AA);
      // response backpressure
      reset_dut();
      resp_ready = 0; cache_hit = 1; cache_rdata = 32'h0BADF00D;
      send(0, 32'h44, 0);
      @(negedge clk);
      cache_hit = 0; cache_rdata = 32'hFFFFFFFF;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", resp_valid, 1);
         check("bp_rdata", resp_rdata, 32'h0BADF00D);
         check("bp_err", resp_err, 0);
         check("bp_req_ready", req_ready, 0);
         check("bp_en", cache_en, 0);
         @(negedge clk);
      end
      resp_ready = 1;
      @(negedge clk);
      check("bp_released_valid", resp_valid, 0);
      check("bp_released_ready", req_ready, 1);
      send(1, 32'h48, 32'h1);
      check("bp_next_en", cache_en, 1);
      check("bp_next_addr", cache_addr, 32'h48);
      check("bp_next_req_cnt", req_cnt, 2);
      // reset in the middle of BUSY
      reset_dut();
      cache_hit = 0;
      send(0, 32'h80, 0);
      @(negedge clk);
      check("mr_en_before", cache_en, 1);
      check("mr_req_cnt_before", req_cnt, 1);
      #2 rst_n = 0;
      #1;
      check("mr_en_async", cache_en, 0);
      check("mr_req_cnt", req_cnt, 0);
      check("mr_miss_cnt", miss_cnt, 0);
      check("mr_resp_valid", resp_valid, 0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mr_post_ready", req_ready, 1);
         check("mr_post_valid", resp_valid, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
